// File: rtl/cycloneii_clk_delay_cal_fsm_pkg.sv
// cycloneii_clk_cal_pkg: shared states, vote directions and delay limit for the clock delay calibration loop
package cycloneii_clk_cal_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, ADJUST, LOCKED, ERROR} cal_state_e;
  typedef enum logic [1:0] {TIE, UP, DOWN} vote_dir_e;
  localparam logic [5:0] DELAY_MAX = 6'd63;
  function automatic vote_dir_e vote_dir(input logic [7:0] up, input logic [7:0] dn);
    return up > dn ? UP : dn > up ? DOWN : TIE;
  endfunction
endpackage

// File: rtl/cycloneii_clk_delay_cal_fsm_if.sv
// cycloneii_clk_cal_if: control, atom-side and status signals between the calibration FSM and its surroundings
interface cycloneii_clk_cal_if;
  logic       start;
  logic       calibratedata;
  logic       pllcalibrateclkdelayedout;
  logic [5:0] delayctrlout;
  logic       disablecalibration;
  logic       busy;
  logic       locked;
  logic       cal_error;
  modport master (
    input  start, calibratedata, pllcalibrateclkdelayedout,
    output delayctrlout, disablecalibration, busy, locked, cal_error
  );
  modport slave (
    output start, calibratedata, pllcalibrateclkdelayedout,
    input  delayctrlout, disablecalibration, busy, locked, cal_error
  );
endinterface

// File: rtl/cycloneii_clk_delay_cal_fsm_sync.sv
// cycloneii_clk_cal_sync: 2-flop synchroniser whose output is either the synchronised level or its rising edge
module cycloneii_clk_cal_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic devclrn,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q, prev_q;
  // two synchroniser stages plus a delayed copy used to spot a 0->1 step
  always_ff @(posedge clk or negedge devclrn)
    if (!devclrn) {meta_q, sync_q, prev_q} <= '0;
    else {meta_q, sync_q, prev_q} <= {d, meta_q, sync_q};
  assign q = EDGE ? sync_q & ~prev_q : sync_q;
endmodule

// File: rtl/cycloneii_clk_delay_cal_fsm.sv
// cycloneii_clk_delay_cal_fsm: walks the atom delay code until the delayed calibrate clock aligns to the data clock
module cycloneii_clk_delay_cal_fsm
  import cycloneii_clk_cal_pkg::*;
#(
  parameter int INIT_DELAY     = 32,
  parameter int SETTLE_CYCLES  = 16,
  parameter int NUM_VOTES      = 8,
  parameter int LOCK_REVERSALS = 3,
  parameter int SAT_LIMIT      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               devclrn,
  cycloneii_clk_cal_if.master cal
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  cal_state_e    state_q, state_d;
  vote_dir_e     last_q, last_d, dir;
  logic [5:0]    code_q, code_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    votes_q, votes_d, up_q, up_d, dn_q, dn_d, rev_q, rev_d, sat_q, sat_d;
  logic          data_s, vote_ev, sat_hit, rev_hit, busy;
  cycloneii_clk_cal_sync #(.EDGE(1'b0)) u_data_sync (
    .clk(clk), .devclrn(devclrn), .d(cal.calibratedata), .q(data_s)
  );
  cycloneii_clk_cal_sync #(.EDGE(1'b1)) u_dly_sync (
    .clk(clk), .devclrn(devclrn), .d(cal.pllcalibrateclkdelayedout), .q(vote_ev)
  );
  assign dir     = vote_dir(up_q, dn_q);
  assign sat_hit = (dir == UP && code_q == DELAY_MAX) || (dir == DOWN && code_q == '0);
  assign rev_hit = dir == TIE || (last_q != TIE && dir != last_q);
  // state and counter registers, all cleared to the idle configuration on devclrn
  always_ff @(posedge clk or negedge devclrn)
    if (!devclrn) begin
      state_q  <= IDLE;
      last_q   <= TIE;
      code_q   <= 6'(INIT_DELAY);
      settle_q <= '0;
      tmo_q    <= '0;
      votes_q  <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      rev_q    <= '0;
      sat_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      code_q   <= code_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      votes_q  <= votes_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      rev_q    <= rev_d;
      sat_q    <= sat_d;
    end
  // next-state logic: settle, gather votes, take one step per decision, start overrides everything
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    code_d   = code_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    votes_d  = votes_q;
    up_d     = up_q;
    dn_d     = dn_q;
    rev_d    = rev_q;
    sat_d    = sat_q;
    case (state_q)
      SETTLE: begin
        settle_d = settle_q == SW'(SETTLE_CYCLES - 1) ? '0 : settle_q + 1'b1;
        state_d  = settle_q == SW'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
      end
      SAMPLE:
        if (vote_ev) begin
          tmo_d   = '0;
          votes_d = votes_q + 8'd1;
          up_d    = up_q + {7'd0, ~data_s};
          dn_d    = dn_q + {7'd0, data_s};
          state_d = votes_q == 8'(NUM_VOTES - 1) ? ADJUST : SAMPLE;
        end else begin
          tmo_d   = tmo_q + 1'b1;
          state_d = tmo_q == TW'(TIMEOUT_CYCLES - 1) ? ERROR : SAMPLE;
        end
      ADJUST: begin
        votes_d = '0;
        up_d    = '0;
        dn_d    = '0;
        tmo_d   = '0;
        last_d  = dir == TIE ? last_q : dir;
        code_d  = sat_hit ? code_q : dir == UP ? code_q + 6'd1 : dir == DOWN ? code_q - 6'd1 : code_q;
        sat_d   = sat_hit ? sat_q + 8'd1 : '0;
        rev_d   = rev_q + {7'd0, rev_hit};
        state_d = sat_d >= 8'(SAT_LIMIT) ? ERROR :
                  rev_d >= 8'(LOCK_REVERSALS) ? LOCKED :
                  code_d != code_q ? SETTLE : SAMPLE;
      end
      default: ;
    endcase
    if (cal.start) begin
      state_d  = SETTLE;
      last_d   = TIE;
      code_d   = 6'(INIT_DELAY);
      settle_d = '0;
      tmo_d    = '0;
      votes_d  = '0;
      up_d     = '0;
      dn_d     = '0;
      rev_d    = '0;
      sat_d    = '0;
    end
  end
  assign busy                   = state_q inside {SETTLE, SAMPLE, ADJUST};
  assign cal.busy               = busy;
  assign cal.disablecalibration = ~busy;
  assign cal.delayctrlout       = code_q;
  assign cal.locked             = state_q == LOCKED;
  assign cal.cal_error          = state_q == ERROR;
endmodule

// File: tb/tb_cycloneii_clk_delay_cal_fsm.sv
// tb_cycloneii_clk_delay_cal_fsm: directed scenarios driving a toy atom model around the calibration FSM
module tb_cycloneii_clk_delay_cal_fsm;
  logic clk = 1'b0;
  logic devclrn = 1'b0;
  int errors = 0;
  int checks = 0;
  int mode = 0;
  bit pll_en = 1'b0;
  logic [1:0] ph = 2'd0;
  cycloneii_clk_cal_if cal();
  cycloneii_clk_delay_cal_fsm dut (.clk(clk), .devclrn(devclrn), .cal(cal));
  always #5 clk = ~clk;
  // atom model: delayed clock of period 4 clk, data changes two cycles before each delayed-clock rise
  initial begin
    cal.calibratedata = 1'b0;
    cal.pllcalibrateclkdelayedout = 1'b0;
    forever begin
      @(negedge clk);
      ph = ph + 2'd1;
      if (!pll_en) cal.pllcalibrateclkdelayedout = 1'b0;
      else begin
        cal.pllcalibrateclkdelayedout = ph[1];
        if (ph == 2'd0)
          cal.calibratedata = mode == 0 ? 1'b0 : mode == 1 ? (cal.delayctrlout >= 6'd40) : ~cal.calibratedata;
      end
    end
  end
  task automatic pulse_start();
    @(negedge clk);
    cal.start = 1'b1;
    @(posedge clk);
    #1 cal.start = 1'b0;
  endtask
  task automatic wait_change(input int bound, output int n);
    logic [5:0] prev;
    prev = cal.delayctrlout;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk);
      #1;
      if (cal.delayctrlout !== prev || cal.locked || cal.cal_error) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic wait_code(input logic [5:0] target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (cal.delayctrlout === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    cal.start = 1'b0;
    #12;
    checks++; if (cal.delayctrlout !== 6'd32) begin errors++; $display("FAIL reset_code: got %0d want 32", cal.delayctrlout); end
    checks++; if (cal.disablecalibration !== 1'b1) begin errors++; $display("FAIL reset_disable: got %b want 1", cal.disablecalibration); end
    checks++; if ({cal.busy, cal.locked, cal.cal_error} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {cal.busy, cal.locked, cal.cal_error}); end
    @(negedge clk);
    devclrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cal.busy !== 1'b0 || cal.delayctrlout !== 6'd32) begin errors++; $display("FAIL idle_hold: busy=%b code=%0d want 0/32", cal.busy, cal.delayctrlout); end
  endtask
  task automatic test_saturate();
    int n;
    bit moved;
    mode = 0;
    pll_en = 1'b1;
    pulse_start();
    checks++; if (cal.busy !== 1'b1 || cal.disablecalibration !== 1'b0) begin errors++; $display("FAIL sat_busy: busy=%b dis=%b want 1/0", cal.busy, cal.disablecalibration); end
    for (int e = 33; e <= 63; e++) begin
      wait_change(200, n);
      checks++; if (n < 0 || cal.delayctrlout !== 6'(e)) begin errors++; $display("FAIL sat_step: got %0d want %0d (n=%0d)", cal.delayctrlout, e, n); end
    end
    moved = 1'b0;
    n = -1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (cal.delayctrlout !== 6'd63) moved = 1'b1;
      if (cal.cal_error) begin n = i; break; end
    end
    checks++; if (n < 0) begin errors++; $display("FAIL sat_error: got cal_error=%b want 1", cal.cal_error); end
    checks++; if (moved || cal.delayctrlout !== 6'd63) begin errors++; $display("FAIL sat_hold: got %0d want 63", cal.delayctrlout); end
    checks++; if ({cal.locked, cal.disablecalibration, cal.busy} !== 3'b010) begin errors++; $display("FAIL sat_status: got %b want 010", {cal.locked, cal.disablecalibration, cal.busy}); end
  endtask
  task automatic test_lock_reversal();
    int n;
    logic [5:0] seq [11] = '{6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd40, 6'd39, 6'd40, 6'd39};
    mode = 1;
    pulse_start();
    checks++; if (cal.delayctrlout !== 6'd32 || cal.cal_error !== 1'b0 || cal.busy !== 1'b1) begin errors++; $display("FAIL restart_from_error: code=%0d err=%b busy=%b want 32/0/1", cal.delayctrlout, cal.cal_error, cal.busy); end
    for (int i = 0; i < 11; i++) begin
      wait_change(200, n);
      checks++; if (n < 0 || cal.delayctrlout !== seq[i]) begin errors++; $display("FAIL rev_step%0d: got %0d want %0d", i, cal.delayctrlout, seq[i]); end
    end
    checks++; if ({cal.locked, cal.disablecalibration, cal.busy, cal.cal_error} !== 4'b1100) begin errors++; $display("FAIL rev_lock: got %b want 1100", {cal.locked, cal.disablecalibration, cal.busy, cal.cal_error}); end
    repeat (100) @(posedge clk);
    #1;
    checks++; if (cal.delayctrlout !== 6'd39 || cal.locked !== 1'b1) begin errors++; $display("FAIL lock_frozen: code=%0d locked=%b want 39/1", cal.delayctrlout, cal.locked); end
  endtask
  task automatic test_ties();
    bit moved;
    int n;
    mode = 2;
    pulse_start();
    checks++; if (cal.delayctrlout !== 6'd32 || cal.locked !== 1'b0) begin errors++; $display("FAIL tie_restart: code=%0d locked=%b want 32/0", cal.delayctrlout, cal.locked); end
    moved = 1'b0;
    n = -1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (cal.delayctrlout !== 6'd32) moved = 1'b1;
      if (cal.locked) begin n = i; break; end
    end
    checks++; if (n < 0) begin errors++; $display("FAIL tie_lock: got locked=%b want 1", cal.locked); end
    checks++; if (moved || cal.delayctrlout !== 6'd32) begin errors++; $display("FAIL tie_code: got %0d want 32 unchanged", cal.delayctrlout); end
  endtask
  task automatic test_timeout();
    pll_en = 1'b0;
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (1039) @(posedge clk);
    #1;
    checks++; if (cal.cal_error !== 1'b0 || cal.busy !== 1'b1) begin errors++; $display("FAIL timeout_early: err=%b busy=%b want 0/1", cal.cal_error, cal.busy); end
    @(posedge clk);
    #1;
    checks++; if (cal.cal_error !== 1'b1 || cal.disablecalibration !== 1'b1) begin errors++; $display("FAIL timeout_fire: err=%b dis=%b want 1/1", cal.cal_error, cal.disablecalibration); end
  endtask
  task automatic test_restart_mid_sample();
    bit ok;
    int n;
    mode = 0;
    pll_en = 1'b1;
    pulse_start();
    wait_code(6'd45, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reach45: got %0d want 45", cal.delayctrlout); end
    repeat (26) @(posedge clk);
    pulse_start();
    checks++; if (cal.delayctrlout !== 6'd32 || cal.busy !== 1'b1) begin errors++; $display("FAIL mid_restart: code=%0d busy=%b want 32/1", cal.delayctrlout, cal.busy); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (cal.delayctrlout !== 6'd32) begin errors++; $display("FAIL votes_cleared: got %0d want 32", cal.delayctrlout); end
    wait_change(200, n);
    checks++; if (n < 0 || cal.delayctrlout !== 6'd33) begin errors++; $display("FAIL after_restart: got %0d want 33", cal.delayctrlout); end
  endtask
  task automatic test_async_reset();
    bit ok;
    wait_code(6'd50, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reach50: got %0d want 50", cal.delayctrlout); end
    repeat (5) @(posedge clk);
    #2 devclrn = 1'b0;
    #1;
    checks++; if (cal.delayctrlout !== 6'd32 || cal.disablecalibration !== 1'b1 || cal.busy !== 1'b0) begin errors++; $display("FAIL async_reset: code=%0d dis=%b busy=%b want 32/1/0", cal.delayctrlout, cal.disablecalibration, cal.busy); end
    @(negedge clk);
    devclrn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (cal.busy !== 1'b0 || cal.delayctrlout !== 6'd32 || cal.disablecalibration !== 1'b1) begin errors++; $display("FAIL stays_idle: busy=%b code=%0d dis=%b want 0/32/1", cal.busy, cal.delayctrlout, cal.disablecalibration); end
    pulse_start();
    checks++; if (cal.busy !== 1'b1) begin errors++; $display("FAIL start_after_reset: busy=%b want 1", cal.busy); end
  endtask
  initial begin
    test_reset();
    test_saturate();
    test_lock_reversal();
    test_ties();
    test_timeout();
    test_restart_mid_sample();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cycloneii_clk_delay_cal_fsm.md
Name: cycloneii_clk_delay_cal_fsm

Overview:
- Closed-loop calibration controller for the clock delay calibration control atom.
- Consumes the atom's two divided-by-2 outputs, calibratedata and pllcalibrateclkdelayedout, and phase-compares them.
- Drives the atom's 6-bit delay control and calibration-disable inputs, walking the delay setting until the delayed calibrate clock is aligned to the data clock, then freezing it.
- Sits in the PLL clock-calibration path beside the atom, in the core clock domain.

Parameters:
- INIT_DELAY, 32: delay code loaded at reset and at every start (0..63).
- SETTLE_CYCLES, 16: clk cycles waited after every delay-code change before voting.
- NUM_VOTES, 8: phase votes per decision (1..255).
- LOCK_REVERSALS, 3: direction reversals (ties included) needed to declare lock.
- SAT_LIMIT, 4: consecutive saturated decisions before error.
- TIMEOUT_CYCLES, 1024: maximum clk cycles without a delayed-clock edge while voting.

Ports:
- clk, input, 1: core clock. All state is on its rising edge.
- devclrn, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse. Begins or restarts calibration from any state.
- calibratedata, input, 1: divided data clock from the atom. Asynchronous to clk.
- pllcalibrateclkdelayedout, input, 1: divided, delayed calibrate clock from the atom. Asynchronous to clk.
- delayctrlout, output, 6: delay code to the atom's delayctrlin.
- disablecalibration, output, 1: drives the atom's disablecalibration.
- busy, output, 1: high in SETTLE, SAMPLE and ADJUST.
- locked, output, 1: high in LOCKED.
- cal_error, output, 1: high in ERROR.

Behaviour:
- Reset values: delayctrlout=INIT_DELAY, disablecalibration=1, busy=0, locked=0, cal_error=0, state IDLE, all counters 0.
- Input synchronisers: both async inputs pass through 2-flop synchronisers.
  - A rising edge on the synchronised delayed clock (0 then 1 on consecutive cycles) is a "vote event".
  - The vote is the synchronised calibratedata sampled in the same cycle: 1 = late (wants decrement), 0 = early (wants increment).
- States:
  - IDLE: disablecalibration=1. On start, load delayctrlout=INIT_DELAY, clear the reversal, saturation and vote counters, go to SETTLE.
  - SETTLE: disablecalibration=0. Count SETTLE_CYCLES cycles, ignoring votes, then go to SAMPLE.
  - SAMPLE: accumulate an up-count and a down-count until NUM_VOTES events are seen, then go to ADJUST. The timeout counter resets on each event; reaching TIMEOUT_CYCLES goes to ERROR.
  - ADJUST (exactly one cycle):
    - up>down: increment; down>up: decrement; tie: hold the code and count a reversal.
    - A reversal is also counted whenever the step direction differs from the previous non-tie direction.
    - Reversals reaching LOCK_REVERSALS goes to LOCKED. Otherwise go to SETTLE if the code changed, else SAMPLE.
  - Saturation: an increment at 63 or a decrement at 0 holds the code and increments the saturation counter. Any non-saturated decision clears it. Reaching SAT_LIMIT goes to ERROR.
  - LOCKED: code frozen, disablecalibration=1, locked=1.
  - ERROR: code frozen, disablecalibration=1, cal_error=1.
- start in any state restarts exactly as from IDLE. start takes priority over a same-cycle ADJUST or timeout transition.
- Output timing: delayctrlout is registered and changes in the cycle after ADJUST. locked and cal_error assert in the cycle the state is entered.
- Latency: one decision takes at least SETTLE_CYCLES + NUM_VOTES·(vote period) + 1 cycles.
- Votes arriving in the ADJUST cycle are discarded.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Decomposition:
- Shared package cycloneii_clk_cal_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, ADJUST, LOCKED, ERROR);
  - the DELAY_MAX=63 constant;
  - the vote-direction typedef (UP, DOWN, TIE).
- One sub-module, cycloneii_clk_cal_sync: 2-flop synchroniser plus rising-edge detect, instantiated once per async input.

Test Plan:
- Reset, then start with all votes 0 (always early), SAT_LIMIT=4: delayctrlout steps 32→63 one per decision, holds at 63, then cal_error=1, disablecalibration=1, locked=0.
- Votes 0 while code<40, 1 while code≥40: code sequence 32..40, 39, 40, 39, then locked=1 on the third reversal with code=39, disablecalibration=1.
- Exactly 4 ones and 4 zeros per decision with NUM_VOTES=8: three ties give locked=1 with delayctrlout=32 and no code change.
- pllcalibrateclkdelayedout held static after start: cal_error=1 exactly TIMEOUT_CYCLES=1024 cycles after entering SAMPLE.
- start pulsed while SAMPLE is mid-way at code=45: next cycle delayctrlout=32, state SETTLE, counters cleared.
- devclrn asserted low during SETTLE at code=50: immediately delayctrlout=32, disablecalibration=1, busy=0; after release the block stays IDLE until start.
